// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: accepts a fetch address, returns the 32-bit word
// after LATENCY cycles over valid/ready channels; a side load port fills the array.
module inst_mem_responder #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] ERR_INST  = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_inst,
    output logic                     resp_err,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_data
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
    localparam logic [32:0] SPAN   = 33'(DEPTH) * 33'd4;

    // Handshake: a beat moves on a channel at a rising edge where valid and ready are both high.
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t         state, state_nxt;
    logic [3:0]     cnt, cnt_nxt;
    logic [31:0]    addr_q;
    logic           accept;
    logic           capture;
    logic [31:0]    cap_addr;
    logic [31:0]    offset;
    logic           cap_err;
    logic [AW-1:0]  cap_idx;
    logic [31:0]    mem [DEPTH];

    assign accept = req_valid && req_ready;

    // With LATENCY=1 the capture happens on the accept edge, so the live address is used.
    assign cap_addr = (state == BUSY) ? addr_q : req_addr;
    assign offset   = cap_addr - BASE_ADDR;
    assign cap_err  = (cap_addr[1:0] != 2'b00) || ({1'b0, offset} >= SPAN);
    assign cap_idx  = offset[AW+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            addr_q    <= 32'h0;
            resp_inst <= 32'h0;
            resp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                addr_q <= req_addr;
            end
            if (capture) begin
                resp_inst <= cap_err ? ERR_INST : mem[cap_idx];
                resp_err  <= cap_err;
            end
        end
    end

    // Array is never reset and loads are not gated by rst; reads see the pre-edge word.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nxt   = LAT_M1;
                    state_nxt = (LATENCY == 1) ? RESP : BUSY;
                    capture   = (LATENCY == 1);
                end
            end
            BUSY: begin
                if (cnt <= 4'd1) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = RESP;
                    capture   = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    if (accept) begin
                        cnt_nxt   = LAT_M1;
                        state_nxt = (LATENCY == 1) ? RESP : BUSY;
                        capture   = (LATENCY == 1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        resp_valid = (state == RESP);
        req_ready  = ((state == IDLE) || ((state == RESP) && resp_ready)) && !rst;
    end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder: a LATENCY=2 instance for most scenarios
// and a LATENCY=1 instance for the load/read collision.
module tb_inst_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, resp_valid, resp_ready, resp_err, load_en;
    logic [31:0] req_addr, resp_inst, load_data;
    logic [7:0]  load_addr;
    logic        req_valid1, req_ready1, resp_valid1, resp_ready1, resp_err1, load_en1;
    logic [31:0] req_addr1, resp_inst1, load_data1;
    logic [7:0]  load_addr1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inst_mem_responder dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_inst(resp_inst), .resp_err(resp_err),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    inst_mem_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .resp_inst(resp_inst1), .resp_err(resp_err1),
        .load_en(load_en1), .load_addr(load_addr1), .load_data(load_data1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic load1(input logic [7:0] a, input logic [31:0] d);
        load_en1 = 1'b1; load_addr1 = a; load_data1 = d;
        tick();
        load_en1 = 1'b0;
    endtask

    // Issue one request from IDLE, wait (bounded) for the response, then complete the handshake.
    task automatic fetch(input logic [31:0] a, output logic [31:0] inst, output logic err, output int cyc);
        req_valid = 1'b1; req_addr = a; resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        cyc = 1;
        while (!resp_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        inst = resp_inst;
        err  = resp_err;
        tick();
    endtask

    task automatic fetch1(input logic [31:0] a, output logic [31:0] inst, output logic err, output int cyc);
        req_valid1 = 1'b1; req_addr1 = a; resp_ready1 = 1'b1;
        tick();
        req_valid1 = 1'b0;
        cyc = 1;
        while (!resp_valid1 && cyc < 20) begin
            tick();
            cyc++;
        end
        inst = resp_inst1;
        err  = resp_err1;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 0; req_addr = 0; resp_ready = 0; load_en = 0; load_addr = 0; load_data = 0;
        req_valid1 = 0; req_addr1 = 0; resp_ready1 = 0; load_en1 = 0; load_addr1 = 0; load_data1 = 0;
        tick();
        tick();
        load(8'd0, 32'h0050_0093);
        load(8'd255, 32'hCAFE_F00D);
        load1(8'd0, 32'h1234_5678);
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %0b want 0", resp_valid); end
        n_vec++; if (resp_inst !== 32'h0) begin n_err++; $display("FAIL reset_resp_inst: got %h want 00000000", resp_inst); end
        n_vec++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL reset_resp_err: got %0b want 0", resp_err); end
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready_in_rst: got %0b want 0", req_ready); end
        n_vec++; if (resp_valid1 !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid_l1: got %0b want 0", resp_valid1); end
        rst = 1'b0;
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready_after: got %0b want 1", req_ready); end
    endtask

    task automatic test_basic;
        logic [31:0] inst;
        logic        err;
        int          cyc;
        fetch(32'h8000_0000, inst, err, cyc);
        n_vec++; if (cyc !== 2) begin n_err++; $display("FAIL basic_latency: got %0d want 2", cyc); end
        n_vec++; if (inst !== 32'h0050_0093) begin n_err++; $display("FAIL basic_inst: got %h want 00500093", inst); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL basic_err: got %0b want 0", err); end
    endtask

    task automatic test_errors;
        logic [31:0] addrs [4];
        logic [31:0] exp_inst [4];
        logic        exp_err [4];
        logic [31:0] inst;
        logic        err;
        int          cyc;
        addrs = '{32'h8000_0002, 32'h8000_0400, 32'h7FFF_FFFC, 32'h8000_03FC};
        exp_inst = '{32'h0000_0013, 32'h0000_0013, 32'h0000_0013, 32'hCAFE_F00D};
        exp_err = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            fetch(addrs[i], inst, err, cyc);
            n_vec++; if (cyc !== 2) begin n_err++; $display("FAIL err_latency[%h]: got %0d want 2", addrs[i], cyc); end
            n_vec++; if (err !== exp_err[i]) begin n_err++; $display("FAIL err_flag[%h]: got %0b want %0b", addrs[i], err, exp_err[i]); end
            n_vec++; if (inst !== exp_inst[i]) begin n_err++; $display("FAIL err_inst[%h]: got %h want %h", addrs[i], inst, exp_inst[i]); end
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        int n_resp;
        load(8'd1, 32'hA5A5_0001);
        req_valid = 1'b1; req_addr = 32'h8000_0004; resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        req_addr = 32'h8000_0002;
        cyc = 1;
        while (!resp_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        n_vec++; if (cyc !== 2) begin n_err++; $display("FAIL bp_latency: got %0d want 2", cyc); end
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, resp_valid); end
            n_vec++; if (resp_inst !== 32'hA5A5_0001) begin n_err++; $display("FAIL bp_inst[%0d]: got %h want a5a50001", i, resp_inst); end
            n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_req_ready[%0d]: got %0b want 0", i, req_ready); end
            tick();
        end
        resp_ready = 1'b1;
        n_resp = 0;
        for (int i = 0; i < 5; i++) begin
            if (resp_valid && resp_ready) n_resp++;
            tick();
        end
        n_vec++; if (n_resp !== 1) begin n_err++; $display("FAIL bp_deliveries: got %0d want 1", n_resp); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_inst [4];
        int sent, got, last, cyc;
        logic acc;
        exp_inst = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 4; i++) load(8'(i), exp_inst[i]);
        req_valid = 1'b1; req_addr = 32'h8000_0000; resp_ready = 1'b1;
        sent = 0; got = 0; last = 0; cyc = 0;
        while (got < 4 && cyc < 40) begin
            acc = req_valid && req_ready;
            tick();
            cyc++;
            if (acc) begin
                sent++;
                if (sent < 4) req_addr = 32'h8000_0000 + 32'(4 * sent);
                else req_valid = 1'b0;
            end
            if (resp_valid) begin
                n_vec++; if (resp_inst !== exp_inst[got]) begin n_err++; $display("FAIL b2b_inst[%0d]: got %h want %h", got, resp_inst, exp_inst[got]); end
                n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_req_ready[%0d]: got %0b want 1", got, req_ready); end
                if (got > 0) begin
                    n_vec++; if (cyc - last !== 2) begin n_err++; $display("FAIL b2b_spacing[%0d]: got %0d want 2", got, cyc - last); end
                end
                last = cyc;
                got++;
            end
        end
        n_vec++; if (got !== 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", got); end
        tick();
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %0b want 0", resp_valid); end
    endtask

    task automatic test_reset_midflight;
        logic [31:0] inst;
        logic        err;
        int          cyc;
        int          n_resp;
        req_valid = 1'b1; req_addr = 32'h8000_0000; resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL mid_req_ready_in_rst: got %0b want 0", req_ready); end
        tick();
        rst = 1'b0;
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL mid_req_ready_after: got %0b want 1", req_ready); end
        n_resp = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid) n_resp++;
            tick();
        end
        n_vec++; if (n_resp !== 0) begin n_err++; $display("FAIL mid_discarded: got %0d responses want 0", n_resp); end
        fetch(32'h8000_0000, inst, err, cyc);
        n_vec++; if (cyc !== 2) begin n_err++; $display("FAIL mid_refetch_latency: got %0d want 2", cyc); end
        n_vec++; if (inst !== 32'h11) begin n_err++; $display("FAIL mid_refetch_inst: got %h want 00000011", inst); end
    endtask

    task automatic test_collision;
        logic [31:0] inst;
        logic        err;
        int          cyc;
        req_valid1 = 1'b1; req_addr1 = 32'h8000_0000; resp_ready1 = 1'b1;
        load_en1 = 1'b1; load_addr1 = 8'd0; load_data1 = 32'hDEAD_BEEF;
        tick();
        req_valid1 = 1'b0;
        load_en1 = 1'b0;
        n_vec++; if (resp_valid1 !== 1'b1) begin n_err++; $display("FAIL coll_valid: got %0b want 1", resp_valid1); end
        n_vec++; if (resp_inst1 !== 32'h1234_5678) begin n_err++; $display("FAIL coll_old_word: got %h want 12345678", resp_inst1); end
        tick();
        fetch1(32'h8000_0000, inst, err, cyc);
        n_vec++; if (cyc !== 1) begin n_err++; $display("FAIL coll_latency: got %0d want 1", cyc); end
        n_vec++; if (inst !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL coll_new_word: got %h want deadbeef", inst); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL coll_err: got %0b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        test_collision();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inst_mem_responder.md
# inst_mem_responder

Instruction-memory responder for the `npc` core's fetch interface: it accepts a fetch address from the core and returns the 32-bit instruction word after a fixed, parameterised latency. It replaces the C-side instruction supply with a synthesizable word-addressed ROM/RAM and a valid/ready handshake on both request and response channels. A separate load port writes program words into the array before or during execution.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two.
- `LATENCY`, 2: cycles from request acceptance to `resp_valid`; legal range 1..15.
- `BASE_ADDR`, 32'h8000_0000: byte address of word 0.
- `ERR_INST`, 32'h0000_0013: word returned on error (`addi x0,x0,0`).

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  core presents a fetch address.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_addr`  in  32  byte address (the core's `pc`).
- `resp_valid`  out  1  `resp_inst`/`resp_err` are valid.
- `resp_ready`  in  1  core consumes the response.
- `resp_inst`  out  32  fetched instruction.
- `resp_err`  out  1  misaligned or out-of-range fetch.
- `load_en`  in  1  write `load_data` into the array this cycle.
- `load_addr`  in  log2(DEPTH)  word index for the load.
- `load_data`  in  32  program word.

## Operation
- FSM states are IDLE, BUSY, and RESP. Reset state is IDLE.
- `req_ready` = (IDLE or (RESP and `resp_ready`)) and not `rst`.
- Accept means `req_valid` and `req_ready` are both high at an edge. On accept:
  - latch `req_addr`;
  - load the counter with LATENCY-1;
  - go to BUSY, or go directly to RESP if LATENCY=1.
- BUSY: the counter decrements each cycle. When the counter is 0, the next state is RESP.
- RESP data is captured on the edge that enters RESP:
  - the offset is the latched address minus `BASE_ADDR`, computed mod 2^32;
  - if `addr[1:0]`≠0 or offset ≥ DEPTH*4: `resp_err`=1 and `resp_inst`=ERR_INST;
  - otherwise `resp_err`=0 and `resp_inst`=mem[offset>>2].
- RESP: `resp_valid`=1. `resp_inst` and `resp_err` are held stable until `resp_ready`=1.
  - On handshake with no new request, go to IDLE.
  - On handshake with a new accept in the same cycle, start the new request (BUSY, or RESP again if LATENCY=1).
- Load port: `load_en` writes mem[`load_addr`] on the edge. It is legal in every state and is not blocked by `rst`.
- Load/read collision: a load and a RESP capture to the same word on the same edge return the old word (read-before-write).
- The memory array is not cleared by reset.

## Timing
- Reset values after any edge with `rst`=1:
  - state IDLE; counter 0;
  - `resp_valid`=0, `resp_inst`=32'h0, `resp_err`=0;
  - `req_ready`=0 while `rst` is high and 1 on the first cycle after.
- Reset mid-operation: a pending request in BUSY or RESP is discarded with no response. Array contents are unchanged.
- Latency: accept at edge N gives `resp_valid`=1 in the cycle after edge N+LATENCY-1, so the response is visible LATENCY cycles after the accept edge.
- Throughput with `resp_ready` held high: one response every LATENCY cycles.
- Backpressure: `resp_valid` stays high and outputs are frozen for as long as `resp_ready`=0. `req_ready` stays 0 during that time.
- `req_addr` is sampled only at accept. Later changes do not affect the response.

## Test plan
- Basic fetch, default parameters:
  - load word 0 = 32'h0050_0093, release reset, request 32'h8000_0000 at edge N;
  - required: `resp_valid` first high after edge N+1, `resp_inst`=32'h0050_0093, `resp_err`=0.
- Back-to-back fetches:
  - load words 0..3 = 32'h11, 32'h22, 32'h33, 32'h44; hold `req_valid` and `resp_ready` high with addresses stepping by 4;
  - required: responses 11, 22, 33, 44, one every 2 cycles, each handshake cycle showing `req_ready`=1.
- Errors:
  - request 32'h8000_0002: required `resp_err`=1, `resp_inst`=32'h0000_0013;
  - request 32'h8000_0400 (offset = DEPTH*4): required `resp_err`=1;
  - request 32'h7FFF_FFFC (below base, wraps): required `resp_err`=1.
- Backpressure:
  - hold `resp_ready`=0 for 5 cycles after `resp_valid` rises;
  - required: `resp_inst` stable, `req_ready`=0 throughout, and exactly one response delivered when `resp_ready` goes high.
- Reset mid-flight:
  - assert `rst` for 1 cycle while in BUSY;
  - required: no `resp_valid` for that request, `req_ready`=1 on the following cycle, and a fresh fetch of word 0 still returns the loaded value.
- Load/read collision:
  - with LATENCY=1, `load_en` writing 32'hDEAD_BEEF to word 0 on the capture edge of a read of word 0;
  - required: `resp_inst` is the old word; the next fetch of word 0 returns 32'hDEAD_BEEF.
